// File: rtl/abs_sum_pkg.sv
// Shared FSM state encodings and accumulator sizing for the serial absolute-sum block.
// Optional saturation is selected with the ABS_SUM_SAT_EN macro (see abs_sum_abs_unit).
package abs_sum_pkg;

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_ABS   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Wide enough that the sum of n signed w-bit operands can never overflow.
    function automatic int acc_width(input int w, input int n);
        return w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/abs_sum_abs_unit.sv
// Combinational magnitude of the signed accumulator, reduced to W bits plus overflow flag.
// ABS_SUM_SAT_EN defined: overflow saturates to 2^W-1; undefined: low W bits (wrap).
module abs_sum_abs_unit #(
    parameter int W  = 4,
    parameter int SW = 7
) (
    input  logic [SW-1:0] i_acc,
    output logic [W-1:0]  o_abs,
    output logic          o_ovf
);

    logic [SW-1:0] w_mag;

    // Two's-complement negate when negative; SW bits keep the most negative sum exact.
    always_comb begin
        w_mag = i_acc;
        o_ovf = 1'b0;
        o_abs = '0;
        if (i_acc[SW-1]) begin
            w_mag = ~i_acc + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            w_mag = i_acc;
        end
        o_ovf = |w_mag[SW-1:W];
`ifdef ABS_SUM_SAT_EN
        if (o_ovf) begin
            o_abs = {W{1'b1}};
        end else begin
            o_abs = w_mag[W-1:0];
        end
`else
        o_abs = w_mag[W-1:0];
`endif
    end

endmodule

// File: rtl/abs_sum_serial.sv
// Serial absolute-sum: accumulates N signed operands per group, then offers |sum| and an
// overflow flag through a valid/ready handshake. Build option: ABS_SUM_SAT_EN (saturate).
module abs_sum_serial
    import abs_sum_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_abs,
    output logic         out_ovf,
    output logic         out_busy
);

    localparam int SW = acc_width(W, N);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    r_state;
    logic [SW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [W-1:0]  r_out_abs;
    logic          r_out_ovf;
    logic          r_busy;

    logic [1:0]    w_state_nxt;
    logic [SW-1:0] w_acc_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [SW-1:0] w_op_sext;
    logic          w_xfer;
    logic [W-1:0]  w_abs;
    logic          w_ovf;

    assign w_op_sext = {{(SW-W){in_data[W-1]}}, in_data};
    assign w_xfer    = in_valid & r_in_ready;

    abs_sum_abs_unit #(.W(W), .SW(SW)) u_abs (
        .i_acc (r_acc),
        .o_abs (w_abs),
        .o_ovf (w_ovf)
    );

    // Next-state, counter and accumulator update.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_ACCUM: begin
                if (w_xfer) begin
                    w_acc_nxt = r_acc + w_op_sext;
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_ABS;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                        w_state_nxt = ST_ACCUM;
                    end
                end else begin
                    w_acc_nxt   = r_acc;
                    w_cnt_nxt   = r_cnt;
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ABS: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                // Accumulator clears on the same edge the result is taken.
                if (out_ready) begin
                    w_state_nxt = ST_ACCUM;
                    w_acc_nxt   = '0;
                end else begin
                    w_state_nxt = ST_HOLD;
                    w_acc_nxt   = r_acc;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, datapath and output registers; in_ready/out_busy are registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_abs   <= '0;
            r_out_ovf   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_in_ready <= (w_state_nxt == ST_ACCUM);
            r_busy     <= (w_state_nxt != ST_ACCUM) | (w_cnt_nxt != '0);
            if (r_state == ST_ABS) begin
                r_out_abs   <= w_abs;
                r_out_ovf   <= w_ovf;
                r_out_valid <= 1'b1;
            end else if ((r_state == ST_HOLD) && out_ready) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_abs   = r_out_abs;
    assign out_ovf   = r_out_ovf;
    assign out_busy  = r_busy;

endmodule

// File: tb/tb_abs_sum_serial.sv
// Directed table-driven bench for abs_sum_serial (W=4, N=4), plus backpressure and reset sequences.
module tb_abs_sum_serial;

`ifdef ABS_SUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_abs;
    logic       out_ovf;
    logic       out_busy;

    int n_cmp;
    int n_bad;

    abs_sum_serial #(.W(4), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_abs   (out_abs),
        .out_ovf   (out_ovf),
        .out_busy  (out_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ops;
        int          gap;
        logic [3:0]  exp_abs;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following the transfer.
    task automatic push(input logic [3:0] d);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: in_ready stayed low for %0d cycles", t);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_group(input logic [15:0] ops, input int gap);
        for (int i = 0; i < 4; i++) begin
            push(ops[15-4*i -: 4]);
            if (gap > 0 && i < 3) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b1;

        vecs[0] = '{16'h3E4F, 0, 4'd4, 1'b0};                    // 3,-2,4,-1
        vecs[1] = '{16'h89AC, 0, SAT ? 4'd15 : 4'd9, 1'b1};      // -8,-7,-6,-4 = -25
        vecs[2] = '{16'h7521, 1, 4'd15, 1'b0};                   // 7,5,2,1 with gaps
        vecs[3] = '{16'hEEEE, 0, 4'd8, 1'b0};                    // -2 x4
        vecs[4] = '{16'h8888, 0, SAT ? 4'd15 : 4'd0, 1'b1};      // -8 x4 = -32
        vecs[5] = '{16'h7777, 2, SAT ? 4'd15 : 4'd12, 1'b1};     // 7 x4 = 28
        vecs[6] = '{16'h0000, 0, 4'd0, 1'b0};
        vecs[7] = '{16'hF1F1, 0, 4'd0, 1'b0};                    // -1,1,-1,1
        vecs[8] = '{16'hDDDD, 0, 4'd12, 1'b0};                   // -3 x4

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_abs", {28'd0, out_abs}, 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        chk("rst_busy", {31'd0, out_busy}, 32'd0);

        for (int v = 0; v < 9; v++) begin
            send_group(vecs[v].ops, vecs[v].gap);
            chk($sformatf("v%0d_valid_early", v), {31'd0, out_valid}, 32'd0);
            chk($sformatf("v%0d_busy_abs", v), {31'd0, out_busy}, 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_valid", v), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_abs", v), {28'd0, out_abs}, {28'd0, vecs[v].exp_abs});
            chk($sformatf("v%0d_ovf", v), {31'd0, out_ovf}, {31'd0, vecs[v].exp_ovf});
            @(negedge clk);
            chk($sformatf("v%0d_valid_drop", v), {31'd0, out_valid}, 32'd0);
            chk($sformatf("v%0d_in_ready", v), {31'd0, in_ready}, 32'd1);
            chk($sformatf("v%0d_busy_idle", v), {31'd0, out_busy}, 32'd0);
        end

        // Backpressure: 1,2,3,4 = 10 held for 5 cycles while a stray operand is offered.
        out_ready = 1'b0;
        send_group(16'h1234, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'd7;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_abs", c), {28'd0, out_abs}, 32'd10);
            chk($sformatf("bp%0d_ovf", c), {31'd0, out_ovf}, 32'd0);
            chk($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp%0d_busy", c), {31'd0, out_busy}, 32'd1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        send_group(16'h111F, 0);                                 // 1,1,1,-1 = 2
        @(negedge clk);
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_next_abs", {28'd0, out_abs}, 32'd2);
        @(negedge clk);

        // Reset after two operands discards the partial group.
        push(4'd5);
        push(4'd5);
        in_valid = 1'b0;
        chk("abort_busy", {31'd0, out_busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy_clr", {31'd0, out_busy}, 32'd0);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_valid_late", {31'd0, out_valid}, 32'd0);
        send_group(16'h1111, 0);
        @(negedge clk);
        chk("abort_next_valid", {31'd0, out_valid}, 32'd1);
        chk("abort_next_abs", {28'd0, out_abs}, 32'd4);
        chk("abort_next_ovf", {31'd0, out_ovf}, 32'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
